// File: rtl/gate_tb_pkg.sv
// gate_tb_pkg: state encodings and expected truth tables shared by the gate
// stimulus/check stage and anything that instantiates it.
package gate_tb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_SAMPLE, ST_FIN} state_t;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: clear/enable counter that flags the last cycle of a DWELL-long
// hold so the caller can sample on the following cycle.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(DWELL) + 1;
  localparam logic [W-1:0] LAST = W'(DWELL - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
  assign tc = en && cnt == LAST;
endmodule

// File: rtl/gate_stim_checker.sv
// gate_stim_checker: walks a combinational gate through every input vector,
// records the sampled output table and scores it against EXPECT.
module gate_stim_checker
  import gate_tb_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int DWELL = 4,
  parameter logic [(1<<N_IN)-1:0] EXPECT = TT_OR2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  output logic [N_IN-1:0]      A_OUT,
  input  logic                 X_IN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [(1<<N_IN)-1:0] RESULT,
  output logic [N_IN:0]        FAIL_CNT,
  output logic [N_IN-1:0]      FAIL_IDX
);
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  if (N_IN < 1 || N_IN > 4) begin : g_bad_n
    $error("gate_stim_checker: N_IN must be 1..4");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("gate_stim_checker: DWELL must be >= 1");
  end
  state_t state;
  logic tc;
  logic miss;
  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk  (CLK),
    .rst_n(RST_N),
    .clr  (state != ST_APPLY),
    .en   (state == ST_APPLY),
    .tc   (tc)
  );
  assign miss = X_IN != EXPECT[A_OUT];
  // A_OUT doubles as the vector index; it returns to 0 on entering FIN.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state    <= ST_IDLE;
      A_OUT    <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      RESULT   <= '0;
      FAIL_CNT <= '0;
      FAIL_IDX <= '0;
    end else begin
      case (state)
        ST_APPLY: if (tc) state <= ST_SAMPLE;
        ST_SAMPLE: begin
          RESULT[A_OUT] <= X_IN;
          if (miss) FAIL_CNT <= FAIL_CNT + 1'b1;
          if (miss && FAIL_CNT == '0) FAIL_IDX <= A_OUT;
          if (A_OUT == LAST_VEC) begin
            state <= ST_FIN;
            A_OUT <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= FAIL_CNT == '0 && !miss;
          end else begin
            state <= ST_APPLY;
            A_OUT <= A_OUT + 1'b1;
          end
        end
        default: if (START) begin
          state    <= ST_APPLY;
          A_OUT    <= '0;
          BUSY     <= 1'b1;
          DONE     <= 1'b0;
          PASS     <= 1'b0;
          RESULT   <= '0;
          FAIL_CNT <= '0;
          FAIL_IDX <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_gate_stim_checker.sv
// tb_gate_stim_checker: scoreboarded directed test of gate_stim_checker with an
// OR/AND gate model (DWELL=4) and an OR gate on a DWELL=1 instance.
module tb_gate_stim_checker;
  import gate_tb_pkg::*;
  typedef struct {
    logic [3:0] result;
    logic [2:0] cnt;
    logic [1:0] idx;
    logic       pass;
    int         cyc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, gsel = 1'b0;
  logic [1:0] a_a, a_b, idx_a, idx_b;
  logic [3:0] res_a, res_b;
  logic [2:0] cnt_a, cnt_b;
  logic busy_a, busy_b, done_a, done_b, pass_a, pass_b, x_a, x_b;
  logic done_qa = 1'b0, done_qb = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  exp_t qa[$], qb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign x_a = gsel ? &a_a : |a_a;
  assign x_b = |a_b;
  gate_stim_checker #(.N_IN(2), .DWELL(4), .EXPECT(TT_OR2)) dut_a (
    .CLK(clk), .RST_N(rst_n), .START(start_a), .A_OUT(a_a), .X_IN(x_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .RESULT(res_a),
    .FAIL_CNT(cnt_a), .FAIL_IDX(idx_a)
  );
  gate_stim_checker #(.N_IN(2), .DWELL(1), .EXPECT(TT_OR2)) dut_b (
    .CLK(clk), .RST_N(rst_n), .START(start_b), .A_OUT(a_b), .X_IN(x_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .RESULT(res_b),
    .FAIL_CNT(cnt_b), .FAIL_IDX(idx_b)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic exp_t mk(logic [3:0] r, logic [2:0] c, logic [1:0] i, logic p, int at);
    exp_t e;
    e.result = r; e.cnt = c; e.idx = i; e.pass = p; e.cyc = at;
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (done_a && !done_qa) begin
      if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_done_cycle", cyc, e.cyc);
        chk("a_result", int'(res_a), int'(e.result));
        chk("a_fail_cnt", int'(cnt_a), int'(e.cnt));
        chk("a_fail_idx", int'(idx_a), int'(e.idx));
        chk("a_pass", int'(pass_a), int'(e.pass));
        chk("a_busy_at_done", int'(busy_a), 0);
      end
    end
    done_qa = done_a;
  end
  always @(negedge clk) begin
    exp_t e;
    if (done_b && !done_qb) begin
      if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_done_cycle", cyc, e.cyc);
        chk("b_result", int'(res_b), int'(e.result));
        chk("b_fail_cnt", int'(cnt_b), int'(e.cnt));
        chk("b_pass", int'(pass_b), int'(e.pass));
      end
    end
    done_qb = done_b;
  end
  initial begin
    int k;
    step(3);
    chk("rst_a_out", int'(a_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_pass", int'(pass_a), 0);
    chk("rst_result", int'(res_a), 0);
    chk("rst_fail_cnt", int'(cnt_a), 0);
    chk("rst_fail_idx", int'(idx_a), 0);
    rst_n = 1'b1;
    step(2);
    // OR gate, single-cycle START: vectors 0..3 held 5 cycles each
    start_a = 1'b1; qa.push_back(mk(4'b1110, 3'd0, 2'd0, 1'b1, cyc + 21));
    step(1); start_a = 1'b0;
    for (int j = 0; j < 20; j++) begin
      chk("or_a_out_step", int'(a_a), j / 5);
      chk("or_busy", int'(busy_a), 1);
      step(1);
    end
    chk("or_done", int'(done_a), 1);
    chk("or_a_out_fin", int'(a_a), 0);
    step(4);
    chk("or_done_held", int'(done_a), 1);
    // AND gate against the OR table
    gsel = 1'b1; start_a = 1'b1;
    qa.push_back(mk(4'b1000, 3'd2, 2'd1, 1'b0, cyc + 21));
    step(1); start_a = 1'b0;
    chk("and_done_cleared", int'(done_a), 0);
    step(22);
    gsel = 1'b0;
    // START re-pulsed mid-run must be ignored
    start_a = 1'b1; qa.push_back(mk(4'b1110, 3'd0, 2'd0, 1'b1, cyc + 21));
    step(1);
    for (int j = 0; j < 20; j++) begin
      start_a = (j == 3 || j == 10);
      step(1);
    end
    start_a = 1'b0;
    step(2);
    // asynchronous reset mid-run
    start_a = 1'b1; step(1); start_a = 1'b0;
    step(8);
    chk("mid_a_out_before_rst", int'(a_a), 1);
    rst_n = 1'b0; #1;
    chk("async_rst_a_out", int'(a_a), 0);
    chk("async_rst_busy", int'(busy_a), 0);
    chk("async_rst_done", int'(done_a), 0);
    chk("async_rst_result", int'(res_a), 0);
    step(2); rst_n = 1'b1; step(5);
    chk("idle_after_rst_busy", int'(busy_a), 0);
    chk("idle_after_rst_done", int'(done_a), 0);
    chk("idle_after_rst_a_out", int'(a_a), 0);
    // START held high: back-to-back runs, DONE every 21 cycles
    k = cyc;
    start_a = 1'b1;
    for (int n = 0; n < 3; n++) qa.push_back(mk(4'b1110, 3'd0, 2'd0, 1'b1, k + 21 + 21 * n));
    step(22);
    chk("held_done_one_cycle", int'(done_a), 0);
    chk("held_busy_again", int'(busy_a), 1);
    step(41);
    start_a = 1'b0;
    step(1);
    chk("held_fin_stays", int'(done_a), 1);
    // DWELL=1 instance: each vector held 2 cycles, DONE after 8
    start_b = 1'b1; qb.push_back(mk(4'b1110, 3'd0, 2'd0, 1'b1, cyc + 9));
    step(1); start_b = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("d1_a_out_step", int'(a_b), j / 2);
      step(1);
    end
    chk("d1_done", int'(done_b), 1);
    start_b = 1'b1; qb.push_back(mk(4'b1110, 3'd0, 2'd0, 1'b1, cyc + 9));
    step(1); start_b = 1'b0;
    chk("d1_restart_done", int'(done_b), 0);
    chk("d1_restart_result", int'(res_b), 0);
    chk("d1_restart_busy", int'(busy_b), 1);
    for (int t = 0; t < 50 && (qa.size() != 0 || qb.size() != 0); t++) step(1);
    chk("pending_a", qa.size(), 0);
    chk("pending_b", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
